// File: rtl/maquina_vendas_troco.sv
// Vending-machine controller: accumulates coin credit in UNITs, dispenses once
// PRICE is reached and pays the overpay or a cancel refund back one UNIT per cycle.
module maquina_vendas_troco #(
  parameter int PRICE    = 6,
  parameter int VAL_A    = 2,
  parameter int VAL_B    = 1,
  parameter int CREDIT_W = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                coin_a,
  input  logic                coin_b,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic                busy
);

  localparam int SUM_W = CREDIT_W + 1;
  localparam logic [SUM_W-1:0]    LP_PRICE_S = SUM_W'(PRICE);
  localparam logic [CREDIT_W-1:0] LP_PRICE_C = CREDIT_W'(PRICE);

  // Worst-case credit is one UNIT short of PRICE plus both coins at once.
  if (PRICE < 1 || (2 ** CREDIT_W) <= (PRICE - 1 + VAL_A + VAL_B)) begin : g_bad_params
    $error("maquina_vendas_troco: PRICE must be >= 1 and CREDIT_W must hold PRICE-1+VAL_A+VAL_B");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_VEND, S_CHANGE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] r_change_left;
  logic                r_reject;
  logic [SUM_W-1:0]    w_add;
  logic [SUM_W-1:0]    w_nxt;
  logic [CREDIT_W-1:0] w_overpay;
  logic                w_sampling;
  logic                w_cancel_ok;
  logic                w_accept;
  logic                w_refuse;

  function automatic logic [SUM_W-1:0] f_coin_add(input logic a, input logic b);
    logic [SUM_W-1:0] va;
    logic [SUM_W-1:0] vb;
    va = a ? SUM_W'(VAL_A) : '0;
    vb = b ? SUM_W'(VAL_B) : '0;
    return va + vb;
  endfunction

  assign w_add       = f_coin_add(coin_a, coin_b);
  assign w_nxt       = {1'b0, r_credit} + w_add;
  assign w_overpay   = r_credit - LP_PRICE_C;
  assign w_sampling  = (r_state == S_IDLE) || (r_state == S_ACCUM);
  // Cancel only means something with credit stored; it then wins over coins.
  assign w_cancel_ok = cancel && (r_state == S_ACCUM);
  assign w_accept    = w_sampling && !w_cancel_ok;
  assign w_refuse    = (coin_a || coin_b) && !w_accept;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_ACCUM: begin
        if (w_cancel_ok)              w_state_nxt = S_CHANGE;
        else if (w_nxt >= LP_PRICE_S) w_state_nxt = S_VEND;
        else if (w_nxt != '0)         w_state_nxt = S_ACCUM;
        else                          w_state_nxt = S_IDLE;
      end
      S_VEND:   w_state_nxt = (r_credit > LP_PRICE_C) ? S_CHANGE : S_IDLE;
      S_CHANGE: w_state_nxt = (r_change_left <= CREDIT_W'(1)) ? S_IDLE : S_CHANGE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    dispense     = (r_state == S_VEND);
    change_pulse = (r_state == S_CHANGE);
    busy         = (r_state == S_VEND) || (r_state == S_CHANGE);
    credit       = r_credit;
    coin_reject  = r_reject;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_credit      <= '0;
      r_change_left <= '0;
      r_reject      <= 1'b0;
    end else begin
      r_reject <= w_refuse;
      case (r_state)
        S_IDLE, S_ACCUM: begin
          if (w_cancel_ok) begin
            r_change_left <= r_credit;
            r_credit      <= '0;
          end else begin
            r_credit <= w_nxt[CREDIT_W-1:0];
          end
        end
        S_VEND: begin
          r_change_left <= w_overpay;
          r_credit      <= '0;
        end
        S_CHANGE: begin
          r_change_left <= (r_change_left <= CREDIT_W'(1)) ? '0 : r_change_left - CREDIT_W'(1);
        end
        default: begin
          r_credit      <= '0;
          r_change_left <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maquina_vendas_troco.sv
// Bench for maquina_vendas_troco: directed vector table, reset-abort sequence,
// then random coins/cancels against a scheduled-output reference model.
module tb_maquina_vendas_troco;

  localparam int PRICE = 6;
  localparam int VAL_A = 2;
  localparam int VAL_B = 1;
  localparam int CW    = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          coin_a = 1'b0;
  logic          coin_b = 1'b0;
  logic          cancel = 1'b0;
  logic [CW-1:0] credit;
  logic          dispense;
  logic          change_pulse;
  logic          coin_reject;
  logic          busy;

  int errors = 0;
  int checks = 0;

  maquina_vendas_troco #(.PRICE(PRICE), .VAL_A(VAL_A), .VAL_B(VAL_B), .CREDIT_W(CW)) dut (
    .clock(clock), .reset(reset), .coin_a(coin_a), .coin_b(coin_b), .cancel(cancel),
    .credit(credit), .dispense(dispense), .change_pulse(change_pulse),
    .coin_reject(coin_reject), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit a; bit b; bit c;
    int cr; bit d; bit ch; bit rj; bit bz;
  } vec_t;
  vec_t vecs[$];

  // Reference model: a queue of outputs for each busy cycle already committed to.
  typedef struct { bit d; bit ch; int cr; } rec_t;
  rec_t q[$];
  int   m_credit;
  bit   m_rej;

  task automatic check(input string name, input int ecr, input bit ed, input bit ech,
                       input bit erj, input bit ebz);
    checks++;
    if (credit !== CW'(ecr) || dispense !== ed || change_pulse !== ech ||
        coin_reject !== erj || busy !== ebz) begin
      errors++;
      $display("FAIL %s: got credit=%0d dispense=%b change_pulse=%b coin_reject=%b busy=%b, expected credit=%0d dispense=%b change_pulse=%b coin_reject=%b busy=%b",
               name, credit, dispense, change_pulse, coin_reject, busy, ecr, ed, ech, erj, ebz);
    end
  endtask

  function automatic void addv(bit a, bit b, bit c, int cr, bit d, bit ch, bit rj, bit bz);
    vec_t v;
    v.a = a; v.b = b; v.c = c; v.cr = cr; v.d = d; v.ch = ch; v.rj = rj; v.bz = bz;
    vecs.push_back(v);
  endfunction

  function automatic void model_reset();
    q.delete();
    m_credit = 0;
    m_rej    = 0;
  endfunction

  function automatic void model_step(bit a, bit b, bit c);
    bit   bsy;
    int   n;
    rec_t r;
    bsy   = (q.size() != 0);
    m_rej = (a || b) && (bsy || (c && m_credit > 0));
    if (bsy) begin
      void'(q.pop_front());
    end else if (c && m_credit > 0) begin
      for (int i = 0; i < m_credit; i++) begin
        r.d = 0; r.ch = 1; r.cr = 0; q.push_back(r);
      end
      m_credit = 0;
    end else begin
      n = m_credit + (a ? VAL_A : 0) + (b ? VAL_B : 0);
      if (n >= PRICE) begin
        r.d = 1; r.ch = 0; r.cr = n; q.push_back(r);
        for (int i = 0; i < n - PRICE; i++) begin
          r.d = 0; r.ch = 1; r.cr = 0; q.push_back(r);
        end
        m_credit = 0;
      end else begin
        m_credit = n;
      end
    end
  endfunction

  initial begin
    bit ra, rb, rc;
    // credit 2,4,6 -> vend, no change
    addv(1,0,0, 0,0,0,0,0); addv(1,0,0, 2,0,0,0,0); addv(1,0,0, 4,0,0,0,0);
    addv(0,0,0, 6,1,0,0,1); addv(0,0,0, 0,0,0,0,0);
    // credit 1,3,5,7 -> vend, one change pulse
    addv(0,1,0, 0,0,0,0,0); addv(1,0,0, 1,0,0,0,0); addv(1,0,0, 3,0,0,0,0);
    addv(1,0,0, 5,0,0,0,0); addv(0,0,0, 7,1,0,0,1); addv(0,0,0, 0,0,1,0,1);
    addv(0,0,0, 0,0,0,0,0);
    // both coins twice -> 3, 6
    addv(1,1,0, 0,0,0,0,0); addv(1,1,0, 3,0,0,0,0); addv(0,0,0, 6,1,0,0,1);
    addv(0,0,0, 0,0,0,0,0);
    // credit 5 then both coins -> 8, two change pulses
    addv(1,0,0, 0,0,0,0,0); addv(1,0,0, 2,0,0,0,0); addv(0,1,0, 4,0,0,0,0);
    addv(1,1,0, 5,0,0,0,0); addv(0,0,0, 8,1,0,0,1); addv(0,0,0, 0,0,1,0,1);
    addv(0,0,0, 0,0,1,0,1); addv(0,0,0, 0,0,0,0,0);
    // credit 4, cancel with coin_a -> coin refused, four pulses
    addv(1,0,0, 0,0,0,0,0); addv(1,0,0, 2,0,0,0,0); addv(1,0,1, 4,0,0,0,0);
    addv(0,0,0, 0,0,1,1,1); addv(0,0,0, 0,0,1,0,1); addv(0,0,0, 0,0,1,0,1);
    addv(0,0,0, 0,0,1,0,1); addv(0,0,0, 0,0,0,0,0);
    // coin during CHANGE is refused, refund count stays 3
    addv(1,0,0, 0,0,0,0,0); addv(0,1,0, 2,0,0,0,0); addv(0,0,1, 3,0,0,0,0);
    addv(1,0,0, 0,0,1,0,1); addv(0,0,0, 0,0,1,1,1); addv(0,0,0, 0,0,1,0,1);
    addv(0,0,0, 0,0,0,0,0);
    // cancel in IDLE ignored, coin alongside it accepted
    addv(0,0,1, 0,0,0,0,0); addv(1,0,1, 0,0,0,0,0); addv(0,0,0, 2,0,0,0,0);
    addv(0,0,1, 2,0,0,0,0); addv(0,0,0, 0,0,1,0,1); addv(0,0,0, 0,0,1,0,1);
    addv(0,0,0, 0,0,0,0,0);

    #2;
    check("reset_state", 0, 0, 0, 0, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    foreach (vecs[i]) begin
      coin_a = vecs[i].a; coin_b = vecs[i].b; cancel = vecs[i].c;
      @(negedge clock);
      check($sformatf("vec%0d", i), vecs[i].cr, vecs[i].d, vecs[i].ch, vecs[i].rj, vecs[i].bz);
      @(posedge clock); #1;
    end

    // Reset asserted in the middle of a refund
    coin_a = 1; coin_b = 0; cancel = 0;
    @(posedge clock); #1;
    coin_a = 1;
    @(posedge clock); #1;
    coin_a = 0; cancel = 1;
    @(posedge clock); #1;
    cancel = 0;
    @(posedge clock); #1;
    @(negedge clock);
    check("in_change_before_reset", 0, 0, 1, 0, 1);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    check("async_reset_mid_change", 0, 0, 0, 0, 0);
    @(negedge clock); #2;
    reset = 1'b1;
    @(negedge clock);
    check("idle_after_reset_release", 0, 0, 0, 0, 0);
    @(posedge clock); #1;

    model_reset();
    for (int i = 0; i < 400; i++) begin
      ra = ($urandom_range(0, 2) == 0);
      rb = ($urandom_range(0, 2) == 0);
      rc = ($urandom_range(0, 9) == 0);
      coin_a = ra; coin_b = rb; cancel = rc;
      @(negedge clock);
      if (q.size() != 0)
        check($sformatf("rand%0d", i), q[0].cr, q[0].d, q[0].ch, m_rej, 1'b1);
      else
        check($sformatf("rand%0d", i), m_credit, 1'b0, 1'b0, m_rej, 1'b0);
      model_step(ra, rb, rc);
      @(posedge clock); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
